// File: rtl/mesi_cache_array_pkg.sv
// Shared types for the direct-mapped MESI cache array: line states, bus
// commands and controller states.
package mesi_pkg;

  typedef enum logic [1:0] {
    ST_I = 2'd0,
    ST_S = 2'd1,
    ST_E = 2'd2,
    ST_M = 2'd3
  } mesi_state_t;

  typedef enum logic [1:0] {
    BUS_RD   = 2'd0,
    BUS_RDX  = 2'd1,
    BUS_UPGR = 2'd2,
    BUS_WB   = 2'd3
  } bus_cmd_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WB   = 3'd1,
    FILL = 3'd2,
    UPGR = 3'd3,
    RESP = 3'd4
  } ctrl_state_t;

  function automatic logic is_valid(input mesi_state_t s);
    return s != ST_I;
  endfunction

endpackage

// File: rtl/mesi_snoop_unit.sv
// Snoop match and MESI next-state for the one line a snoop address selects;
// purely combinational, the owner applies next_state on the next edge.
module mesi_snoop_unit
  import mesi_pkg::*;
#(
  parameter int TAG_W = 24
) (
  input  logic             snp_valid,
  input  bus_cmd_t         snp_cmd,
  input  logic [TAG_W-1:0] snp_tag,
  input  logic [TAG_W-1:0] line_tag,
  input  mesi_state_t      line_state,
  output logic             snp_hit,
  output logic             snp_flush,
  output mesi_state_t      next_state
);

  // Match against the indexed line and derive the downgraded state
  always_comb begin
    snp_hit    = snp_valid && is_valid(line_state) && (line_tag == snp_tag);
    snp_flush  = 1'b0;
    next_state = line_state;
    if (snp_hit) begin
      case (snp_cmd)
        BUS_RD: begin
          snp_flush  = (line_state == ST_M);
          next_state = ST_S;
        end
        BUS_RDX: begin
          snp_flush  = (line_state == ST_M);
          next_state = ST_I;
        end
        BUS_UPGR: next_state = (line_state == ST_S) ? ST_I : line_state;
        BUS_WB:   next_state = line_state;
        default:  next_state = line_state;
      endcase
    end else begin
      next_state = line_state;
    end
  end

endmodule

// File: rtl/mesi_cache_array.sv
// Direct-mapped MESI cache tag/state array with a single-request controller
// (writeback, fill, upgrade) and every-cycle snoop handling.
module mesi_cache_array
  import mesi_pkg::*;
#(
  parameter  int ADDR_W    = 32,
  parameter  int NUM_LINES = 16,
  parameter  int OFF_W     = 4,
  localparam int IDX_W     = $clog2(NUM_LINES),
  localparam int TAG_W     = ADDR_W - IDX_W - OFF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  input  logic              cpu_req_write,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  output logic              cpu_req_ready,
  output logic              cpu_resp_valid,
  output logic              cpu_resp_hit,
  output logic              bus_req_valid,
  output logic [1:0]        bus_req_cmd,
  output logic [ADDR_W-1:0] bus_req_addr,
  input  logic              bus_gnt,
  input  logic              bus_shared,
  input  logic              snp_valid,
  input  logic [1:0]        snp_cmd,
  input  logic [ADDR_W-1:0] snp_addr,
  output logic              snp_hit,
  output logic              snp_flush,
  input  logic [IDX_W-1:0]  dbg_idx,
  output logic [1:0]        dbg_state
);

  mesi_state_t       state_q [NUM_LINES];
  mesi_state_t       state_d [NUM_LINES];
  logic [TAG_W-1:0]  tag_q   [NUM_LINES];
  logic [TAG_W-1:0]  tag_d   [NUM_LINES];
  ctrl_state_t       ctrl_q, ctrl_d;
  logic              req_write_q, req_write_d;
  logic [TAG_W-1:0]  req_tag_q, req_tag_d;
  logic [IDX_W-1:0]  req_idx_q, req_idx_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_hit_q, resp_hit_d;
  logic              bus_valid_q, bus_valid_d;
  bus_cmd_t          bus_cmd_q, bus_cmd_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;

  logic [IDX_W-1:0]  cpu_idx_s, snp_idx_s;
  logic [TAG_W-1:0]  cpu_tag_s, snp_tag_s;
  logic              cpu_hit_s, accept_s;
  logic              snp_hit_s, snp_flush_s, snp_kills_req_s;
  mesi_state_t       snp_next_s;
  logic              unused_addr_bits_s;

  assign cpu_idx_s = cpu_req_addr[OFF_W +: IDX_W];
  assign cpu_tag_s = cpu_req_addr[ADDR_W-1 -: TAG_W];
  assign snp_idx_s = snp_addr[OFF_W +: IDX_W];
  assign snp_tag_s = snp_addr[ADDR_W-1 -: TAG_W];
  assign unused_addr_bits_s = ^{cpu_req_addr[OFF_W-1:0], snp_addr[OFF_W-1:0]};

  assign cpu_hit_s = is_valid(state_q[cpu_idx_s]) && (tag_q[cpu_idx_s] == cpu_tag_s);
  assign cpu_req_ready = (ctrl_q == IDLE) && !snp_valid;
  assign accept_s = cpu_req_valid && cpu_req_ready;

  mesi_snoop_unit #(.TAG_W(TAG_W)) u_snoop (
    .snp_valid  (snp_valid),
    .snp_cmd    (bus_cmd_t'(snp_cmd)),
    .snp_tag    (snp_tag_s),
    .line_tag   (tag_q[snp_idx_s]),
    .line_state (state_q[snp_idx_s]),
    .snp_hit    (snp_hit_s),
    .snp_flush  (snp_flush_s),
    .next_state (snp_next_s)
  );

  // A pending upgrade is lost once a snoop invalidates the line it targets
  assign snp_kills_req_s = snp_hit_s && (snp_idx_s == req_idx_q) && (snp_next_s == ST_I);

  assign snp_hit        = snp_hit_s;
  assign snp_flush      = snp_flush_s;
  assign dbg_state      = state_q[dbg_idx];
  assign cpu_resp_valid = resp_valid_q;
  assign cpu_resp_hit   = resp_hit_q;
  assign bus_req_valid  = bus_valid_q;
  assign bus_req_cmd    = bus_cmd_q;
  assign bus_req_addr   = bus_addr_q;

  // Next line state, controller state and registered outputs
  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    ctrl_d      = ctrl_q;
    req_write_d = req_write_q;
    req_tag_d   = req_tag_q;
    req_idx_d   = req_idx_q;

    // Snoop first so that a same-cycle grant update below overrides it
    if (snp_hit_s) begin
      state_d[snp_idx_s] = snp_next_s;
    end else begin
      state_d[snp_idx_s] = state_q[snp_idx_s];
    end

    case (ctrl_q)
      IDLE: begin
        if (accept_s) begin
          req_write_d = cpu_req_write;
          req_tag_d   = cpu_tag_s;
          req_idx_d   = cpu_idx_s;
          if (cpu_hit_s && (!cpu_req_write || state_q[cpu_idx_s] != ST_S)) begin
            if (cpu_req_write) begin
              state_d[cpu_idx_s] = ST_M;
            end else begin
              state_d[cpu_idx_s] = state_q[cpu_idx_s];
            end
            ctrl_d = RESP;
          end else if (cpu_hit_s) begin
            ctrl_d = UPGR;
          end else if (state_q[cpu_idx_s] == ST_M) begin
            ctrl_d = WB;
          end else begin
            state_d[cpu_idx_s] = ST_I;
            ctrl_d = FILL;
          end
        end else begin
          ctrl_d = IDLE;
        end
      end
      WB: begin
        if (bus_gnt) begin
          state_d[req_idx_q] = ST_I;
          ctrl_d = FILL;
        end else begin
          ctrl_d = WB;
        end
      end
      FILL: begin
        if (bus_gnt) begin
          tag_d[req_idx_q] = req_tag_q;
          if (req_write_q) begin
            state_d[req_idx_q] = ST_M;
          end else if (bus_shared) begin
            state_d[req_idx_q] = ST_S;
          end else begin
            state_d[req_idx_q] = ST_E;
          end
          ctrl_d = RESP;
        end else begin
          ctrl_d = FILL;
        end
      end
      UPGR: begin
        if (bus_gnt) begin
          state_d[req_idx_q] = ST_M;
          ctrl_d = RESP;
        end else if (snp_kills_req_s) begin
          ctrl_d = FILL;
        end else begin
          ctrl_d = UPGR;
        end
      end
      RESP:    ctrl_d = IDLE;
      default: ctrl_d = IDLE;
    endcase

    resp_valid_d = (ctrl_d == RESP);
    resp_hit_d   = (ctrl_d == RESP) && (ctrl_q == IDLE);

    bus_valid_d = 1'b0;
    bus_cmd_d   = BUS_RD;
    bus_addr_d  = '0;
    case (ctrl_d)
      WB: begin
        bus_valid_d = 1'b1;
        bus_cmd_d   = BUS_WB;
        bus_addr_d  = {tag_q[req_idx_d], req_idx_d, {OFF_W{1'b0}}};
      end
      FILL: begin
        bus_valid_d = 1'b1;
        bus_cmd_d   = req_write_d ? BUS_RDX : BUS_RD;
        bus_addr_d  = {req_tag_d, req_idx_d, {OFF_W{1'b0}}};
      end
      UPGR: begin
        bus_valid_d = 1'b1;
        bus_cmd_d   = BUS_UPGR;
        bus_addr_d  = {req_tag_d, req_idx_d, {OFF_W{1'b0}}};
      end
      default: begin
        bus_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        state_q[i] <= ST_I;
        tag_q[i]   <= '0;
      end
      ctrl_q       <= IDLE;
      req_write_q  <= 1'b0;
      req_tag_q    <= '0;
      req_idx_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      bus_valid_q  <= 1'b0;
      bus_cmd_q    <= BUS_RD;
      bus_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      ctrl_q       <= ctrl_d;
      req_write_q  <= req_write_d;
      req_tag_q    <= req_tag_d;
      req_idx_q    <= req_idx_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      bus_valid_q  <= bus_valid_d;
      bus_cmd_q    <= bus_cmd_d;
      bus_addr_q   <= bus_addr_d;
    end
  end

endmodule
